// File: rtl/tmu2_alpha.sv
// TMU2 alpha blending stage: 3-deep flow-through pipeline blending source and destination RGB565 pixels.
// Optional build macro TMU2_ALPHA_ROUND_EN selects round-half-up instead of truncation before saturation.
module tmu2_alpha #(
   parameter int unsigned fml_depth = 26
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   output logic                   busy,
   input  logic [5:0]             alpha,
   input  logic                   additive,
   input  logic                   pipe_stb_i,
   output logic                   pipe_ack_o,
   input  logic [15:0]            color,
   input  logic [fml_depth-2:0]   dadr,
   input  logic [15:0]            dcolor,
   output logic                   pipe_stb_o,
   input  logic                   pipe_ack_i,
   output logic [15:0]            acolor,
   output logic [fml_depth-2:0]   dadr_f
);

   localparam int unsigned AW = fml_depth - 1;
   localparam int unsigned SW = 13;

   logic          valid1_q, valid2_q, valid3_q;
   logic          en;

   logic [15:0]   color1_q, dcolor1_q;
   logic [AW-1:0] dadr1_q, dadr2_q, dadr3_q;
   logic [6:0]    a1_q, na1_q;
   logic [6:0]    a_d, na_d;

   logic [SW-1:0] sr2_q, sg2_q, sb2_q;
   logic [SW-1:0] sr_d, sg_d, sb_d;

   logic [15:0]   acolor_q, acolor_d;

   logic [SW-1:0] rr, rg, rb;
   logic [6:0]    r7, g7, b7;
   logic [4:0]    r5, b5;
   logic [5:0]    g6;

   assign en         = ~valid3_q | pipe_ack_i;
   assign pipe_ack_o = en;
   assign pipe_stb_o = valid3_q;
   assign busy       = valid1_q | valid2_q | valid3_q;
   assign acolor     = acolor_q;
   assign dadr_f     = dadr3_q;

   // Weights for stage 1, channel sums for stage 2, shift/saturate/pack for stage 3.
   always_comb begin
      a_d  = 7'(alpha) + 7'd1;
      na_d = additive ? 7'd64 : (7'd64 - a_d);

      sr_d = SW'(color1_q[15:11]) * SW'(a1_q) + SW'(dcolor1_q[15:11]) * SW'(na1_q);
      sg_d = SW'(color1_q[10:5])  * SW'(a1_q) + SW'(dcolor1_q[10:5])  * SW'(na1_q);
      sb_d = SW'(color1_q[4:0])   * SW'(a1_q) + SW'(dcolor1_q[4:0])   * SW'(na1_q);

`ifdef TMU2_ALPHA_ROUND_EN
      // Largest sum is 8064, so adding the half-LSB still fits in 13 bits.
      rr = sr2_q + SW'(32);
      rg = sg2_q + SW'(32);
      rb = sb2_q + SW'(32);
`else
      rr = sr2_q;
      rg = sg2_q;
      rb = sb2_q;
`endif

      r7 = rr[SW-1:6];
      g7 = rg[SW-1:6];
      b7 = rb[SW-1:6];
      r5 = (r7 > 7'd31) ? 5'd31 : r7[4:0];
      g6 = (g7 > 7'd63) ? 6'd63 : g7[5:0];
      b5 = (b7 > 7'd31) ? 5'd31 : b7[4:0];
      acolor_d = {r5, g6, b5};
   end

   // Whole pipeline advances together on en, holds otherwise.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         valid1_q  <= 1'b0;
         valid2_q  <= 1'b0;
         valid3_q  <= 1'b0;
         color1_q  <= '0;
         dcolor1_q <= '0;
         dadr1_q   <= '0;
         a1_q      <= '0;
         na1_q     <= '0;
         sr2_q     <= '0;
         sg2_q     <= '0;
         sb2_q     <= '0;
         dadr2_q   <= '0;
         acolor_q  <= '0;
         dadr3_q   <= '0;
      end else if (en) begin
         valid1_q  <= pipe_stb_i;
         valid2_q  <= valid1_q;
         valid3_q  <= valid2_q;
         color1_q  <= color;
         dcolor1_q <= dcolor;
         dadr1_q   <= dadr;
         a1_q      <= a_d;
         na1_q     <= na_d;
         sr2_q     <= sr_d;
         sg2_q     <= sg_d;
         sb2_q     <= sb_d;
         dadr2_q   <= dadr1_q;
         acolor_q  <= acolor_d;
         dadr3_q   <= dadr2_q;
      end
   end

endmodule
